// File: rtl/song_sequencer_pkg.sv
// Shared definitions for the song sequencer and the note player side:
// FSM state encoding, note/duration widths and the end-of-song marker.
package song_sequencer_pkg;

    localparam int NOTE_WIDTH = 6;
    localparam int DUR_WIDTH  = 6;

    // A ROM entry with a zero duration terminates the song.
    localparam logic [DUR_WIDTH-1:0] END_MARKER = '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_READ,
        S_LOAD,
        S_WAIT_DONE,
        S_DONE
    } state_t;

endpackage

// File: rtl/song_sequencer.sv
// Walks the selected song in an external synchronous ROM and hands one
// note/duration pair at a time to the note player, pacing on its done level.
module song_sequencer
    import song_sequencer_pkg::*;
#(
    parameter int NOTE_W    = NOTE_WIDTH,
    parameter int DUR_W     = DUR_WIDTH,
    parameter int SONG_BITS = 2,
    parameter int IDX_BITS  = 5
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          play,
    input  logic [SONG_BITS-1:0]          song,
    output logic [SONG_BITS+IDX_BITS-1:0] rom_addr,
    input  logic [NOTE_W+DUR_W-1:0]       rom_data,
    output logic [NOTE_W-1:0]             note_to_load,
    output logic [DUR_W-1:0]              duration_to_load,
    output logic                          load_new_note,
    input  logic                          done_with_note,
    output logic                          song_done
);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [SONG_BITS-1:0]  r_song_q;
    logic [IDX_BITS-1:0]   r_idx;
    logic [IDX_BITS-1:0]   w_idx_nxt;
    logic                  r_armed;
    logic                  w_armed_nxt;
    logic [NOTE_W-1:0]     r_note;
    logic [DUR_W-1:0]      r_dur;
    logic                  w_song_chg;
    logic                  w_latch;
    logic [NOTE_W-1:0]     w_rom_note;
    logic [DUR_W-1:0]      w_rom_dur;

    assign w_song_chg = (song != r_song_q);
    assign w_rom_note = rom_data[NOTE_W+DUR_W-1:DUR_W];
    assign w_rom_dur  = rom_data[DUR_W-1:0];

    assign rom_addr         = {r_song_q, r_idx};
    assign note_to_load     = r_note;
    assign duration_to_load = r_dur;
    assign song_done        = (r_state == S_DONE);

    // A song change overrides everything, even while paused.
    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_armed_nxt   = r_armed;
        w_latch       = 1'b0;
        load_new_note = 1'b0;
        if (w_song_chg) begin
            w_state_nxt = S_FETCH;
            w_idx_nxt   = '0;
            w_armed_nxt = 1'b0;
        end else if (play) begin
            case (r_state)
                S_IDLE:  w_state_nxt = S_FETCH;
                S_FETCH: w_state_nxt = S_READ;
                S_READ: begin
                    if (w_rom_dur == DUR_W'(END_MARKER)) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_latch     = 1'b1;
                        w_state_nxt = S_LOAD;
                    end
                end
                S_LOAD: begin
                    load_new_note = 1'b1;
                    w_armed_nxt   = 1'b0;
                    w_state_nxt   = S_WAIT_DONE;
                end
                // done must be seen low once after the load before it counts
                S_WAIT_DONE: begin
                    if (!done_with_note) begin
                        w_armed_nxt = 1'b1;
                    end else if (r_armed) begin
                        if (&r_idx) begin
                            w_state_nxt = S_DONE;
                        end else begin
                            w_idx_nxt   = r_idx + 1'b1;
                            w_state_nxt = S_FETCH;
                        end
                    end
                end
                S_DONE:  w_state_nxt = S_DONE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_song_q <= song;
            r_idx    <= '0;
            r_armed  <= 1'b0;
            r_note   <= '0;
            r_dur    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_armed <= w_armed_nxt;
            if (w_song_chg) begin
                r_song_q <= song;
            end
            if (w_latch) begin
                r_note <= w_rom_note;
                r_dur  <= w_rom_dur;
            end
        end
    end

endmodule
